obstacle_scheduler: RTL and testbench

Sequences the obstacle field for the game. It owns the per-obstacle top-left coordinates of 40x40 obstacles and scrolls them left once per video frame. When an obstacle leaves the screen it is respawned at the right edge with a pseudo-random height. It also runs the game-level state (idle/run/pause/over) and counts passed obstacles; the packed outputs feed the renderer and the collision checker directly.

---
 rtl/obstacle_scheduler.sv | 137 +++++++++++++
 tb/tb_obstacle_scheduler.sv | 227 ++++++++++++++++++++++
 2 files changed

// File: rtl/obstacle_scheduler.sv
// Obstacle field sequencer: scrolls NUM_OBS obstacles left per frame, respawns them with LFSR heights, runs game FSM and score.
// Optional build macro OBSTACLE_SPEEDUP_EN raises the scroll speed every 8th respawn up to MAX_SPEED.
module obstacle_scheduler #(
  parameter int NUM_OBS   = 3,
  parameter int OBS_SIZE  = 40,
  parameter int SCREEN_W  = 640,
  parameter int SCREEN_H  = 480,
  parameter int SPEED     = 2,
  parameter logic [10*NUM_OBS-1:0] INIT_X = {10'd160, 10'd230, 10'd300},
  parameter logic [9*NUM_OBS-1:0]  INIT_Y = {9'd20, 9'd200, 9'd300},
  parameter int MAX_SPEED = 8
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   frame_tick,
  input  logic                   start,
  input  logic                   pause,
  input  logic                   collision,
  output logic [10*NUM_OBS-1:0]  obstacle_x,
  output logic [9*NUM_OBS-1:0]   obstacle_y,
  output logic [15:0]            score,
  output logic [1:0]             game_state
);

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    RUN    = 2'd1,
    PAUSED = 2'd2,
    OVER   = 2'd3
  } state_t;

  localparam int Y_LIM = SCREEN_H - OBS_SIZE;
  // Starting speed is clamped so it can never sit above the ceiling.
  localparam logic [3:0] BASE_SPEED = 4'((SPEED < MAX_SPEED) ? SPEED : MAX_SPEED);

  state_t              state;
  logic [15:0]         lfsr;
  logic [3:0]          speed;
  logic                restart;
  logic                move;
  logic [10*NUM_OBS-1:0] next_x;
  logic [9*NUM_OBS-1:0]  next_y;
  logic [3:0]          respawn_cnt;
  logic [8:0]          cand;
  logic [16:0]         score_sum;

  assign game_state = state;
  assign restart    = start && ((state == IDLE) || (state == OVER));
  assign move       = (state == RUN) && !collision && !pause && frame_tick;
  assign score_sum  = {1'b0, score} + 17'(respawn_cnt);

`ifdef OBSTACLE_SPEEDUP_EN
  localparam logic [3:0] SPEED_CAP = 4'(MAX_SPEED);

  logic [3:0] speed_q;
  logic [2:0] resp_mod;
  logic [3:0] mod_sum;

  assign speed   = speed_q;
  assign mod_sum = {1'b0, resp_mod} + respawn_cnt;

  // A carry out of the 3-bit respawn counter marks the 8th respawn.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      speed_q  <= BASE_SPEED;
      resp_mod <= 3'd0;
    end else if (restart) begin
      speed_q  <= BASE_SPEED;
      resp_mod <= 3'd0;
    end else if (move) begin
      resp_mod <= mod_sum[2:0];
      if (mod_sum[3] && (speed_q < SPEED_CAP))
        speed_q <= speed_q + 4'd1;
    end
  end
`else
  assign speed = BASE_SPEED;
`endif

  always_comb begin
    next_x      = obstacle_x;
    next_y      = obstacle_y;
    respawn_cnt = 4'd0;
    cand        = 9'd0;
    for (int k = 0; k < NUM_OBS; k++) begin
      cand = lfsr[k +: 9];
      if (obstacle_x[10*k +: 10] >= 10'(speed)) begin
        next_x[10*k +: 10] = obstacle_x[10*k +: 10] - 10'(speed);
      end else begin
        next_x[10*k +: 10] = 10'(SCREEN_W);
        next_y[9*k +: 9]   = (cand <= 9'(Y_LIM)) ? cand : (cand - 9'd256);
        respawn_cnt        = respawn_cnt + 4'd1;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)
      lfsr <= 16'hACE1;
    else
      lfsr <= {lfsr[14:0], lfsr[15] ^ lfsr[13] ^ lfsr[12] ^ lfsr[10]};
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state      <= IDLE;
      obstacle_x <= INIT_X;
      obstacle_y <= INIT_Y;
      score      <= 16'd0;
    end else begin
      case (state)
        IDLE: if (start) state <= RUN;
        RUN: begin
          if (collision)  state <= OVER;
          else if (pause) state <= PAUSED;
        end
        PAUSED: begin
          if (collision)   state <= OVER;
          else if (!pause) state <= RUN;
        end
        OVER: if (start) state <= RUN;
        default: state <= IDLE;
      endcase

      if (restart) begin
        obstacle_x <= INIT_X;
        obstacle_y <= INIT_Y;
        score      <= 16'd0;
      end else if (move) begin
        obstacle_x <= next_x;
        obstacle_y <= next_y;
        score      <= score_sum[16] ? 16'hFFFF : score_sum[15:0];
      end
    end
  end

endmodule

// File: tb/tb_obstacle_scheduler.sv
// Scoreboard bench for obstacle_scheduler: an independent behavioural model pushes expected outputs per step.
module tb_obstacle_scheduler;

  localparam int NUM_OBS = 3;
  localparam logic [29:0] INIT_X = {10'd160, 10'd230, 10'd300};
  localparam logic [26:0] INIT_Y = {9'd20, 9'd200, 9'd300};

  logic        clk;
  logic        rst_n;
  logic        frame_tick;
  logic        start;
  logic        pause;
  logic        collision;
  logic [29:0] obstacle_x;
  logic [26:0] obstacle_y;
  logic [15:0] score;
  logic [1:0]  game_state;

  typedef struct {
    logic [29:0] x;
    logic [26:0] y;
    logic [15:0] score;
    logic [1:0]  state;
  } exp_t;

  exp_t exp_q[$];

  int n_checks = 0;
  int n_pass   = 0;
  int n_fail   = 0;

  int          m_x[NUM_OBS];
  int          m_y[NUM_OBS];
  int          m_score;
  int          m_state;
  int          m_speed;
  int          m_cnt;
  logic [15:0] m_lfsr;

  obstacle_scheduler dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .frame_tick (frame_tick),
    .start      (start),
    .pause      (pause),
    .collision  (collision),
    .obstacle_x (obstacle_x),
    .obstacle_y (obstacle_y),
    .score      (score),
    .game_state (game_state)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic compare(input string tag, input logic [31:0] obs, input logic [31:0] req);
    n_checks++;
    assert (obs === req) n_pass++;
    else begin
      n_fail++;
      $error("[TB] FAIL %s: observed %0d expected %0d", tag, obs, req);
    end
  endtask

  task automatic modelReset();
    for (int k = 0; k < NUM_OBS; k++) begin
      m_x[k] = int'(INIT_X[10*k +: 10]);
      m_y[k] = int'(INIT_Y[9*k +: 9]);
    end
    m_score = 0;
    m_state = 0;
    m_speed = 2;
    m_cnt   = 0;
    m_lfsr  = 16'hACE1;
  endtask

  task automatic modelRestart();
    for (int k = 0; k < NUM_OBS; k++) begin
      m_x[k] = int'(INIT_X[10*k +: 10]);
      m_y[k] = int'(INIT_Y[9*k +: 9]);
    end
    m_score = 0;
    m_speed = 2;
    m_cnt   = 0;
    m_state = 1;
  endtask

  task automatic modelMove();
    int n;
    int c;
    n = 0;
    for (int k = 0; k < NUM_OBS; k++) begin
      if (m_x[k] >= m_speed) begin
        m_x[k] = m_x[k] - m_speed;
      end else begin
        m_x[k] = 640;
        c = int'((m_lfsr >> k) & 16'h01FF);
        m_y[k] = (c <= 440) ? c : c - 256;
        n++;
      end
    end
    m_score = (m_score + n > 65535) ? 65535 : m_score + n;
`ifdef OBSTACLE_SPEEDUP_EN
    m_cnt = m_cnt + n;
    if (m_cnt >= 8) begin
      m_cnt = m_cnt - 8;
      if (m_speed < 8) m_speed++;
    end
`endif
  endtask

  // Drive one cycle of inputs, advance the model, queue what the DUT must show after the edge.
  task automatic applyStimulus(input logic st, input logic pa, input logic co, input logic ti);
    exp_t e;
    start      = st;
    pause      = pa;
    collision  = co;
    frame_tick = ti;
    case (m_state)
      0: if (st) modelRestart();
      1: begin
        if (co)      m_state = 3;
        else if (pa) m_state = 2;
        else if (ti) modelMove();
      end
      2: begin
        if (co)       m_state = 3;
        else if (!pa) m_state = 1;
      end
      default: if (st) modelRestart();
    endcase
    m_lfsr = {m_lfsr[14:0], m_lfsr[15] ^ m_lfsr[13] ^ m_lfsr[12] ^ m_lfsr[10]};
    for (int k = 0; k < NUM_OBS; k++) begin
      e.x[10*k +: 10] = 10'(m_x[k]);
      e.y[9*k +: 9]   = 9'(m_y[k]);
    end
    e.score = 16'(m_score);
    e.state = 2'(m_state);
    exp_q.push_back(e);
    @(posedge clk);
    #1;
  endtask

  task automatic checkOutput();
    exp_t e;
    if (exp_q.size() == 0) begin
      compare("queue_empty", 32'd1, 32'd0);
    end else begin
      e = exp_q.pop_front();
      compare("x", {2'b0, obstacle_x}, {2'b0, e.x});
      compare("y", {5'b0, obstacle_y}, {5'b0, e.y});
      compare("score", {16'b0, score}, {16'b0, e.score});
      compare("state", {30'b0, game_state}, {30'b0, e.state});
    end
  endtask

  task automatic step(input logic st, input logic pa, input logic co, input logic ti);
    applyStimulus(st, pa, co, ti);
    checkOutput();
  endtask

  task automatic checkResetValues(input string tag);
    compare({tag, "_x"}, {2'b0, obstacle_x}, {2'b0, INIT_X});
    compare({tag, "_y"}, {5'b0, obstacle_y}, {5'b0, INIT_Y});
    compare({tag, "_score"}, {16'b0, score}, 32'd0);
    compare({tag, "_state"}, {30'b0, game_state}, 32'd0);
  endtask

  initial begin
    rst_n      = 1'b0;
    start      = 1'b0;
    pause      = 1'b0;
    collision  = 1'b0;
    frame_tick = 1'b0;
    modelReset();
    #12;
    checkResetValues("reset");
    rst_n = 1'b1;

    $display("[TB] idle ticks without start");
    for (int i = 0; i < 5; i++) step(1'b0, 1'b0, 1'b0, 1'b1);

    $display("[TB] start then scroll");
    step(1'b1, 1'b0, 1'b0, 1'b0);
    step(1'b1, 1'b0, 1'b0, 1'b0);
    step(1'b0, 1'b0, 1'b0, 1'b1);
    compare("first_move_x", {2'b0, obstacle_x}, {2'b0, 10'd158, 10'd228, 10'd298});

    $display("[TB] scroll until first respawn");
    for (int i = 0; i < 85; i++) step(1'b0, 1'b0, 1'b0, (i % 17) != 5);

    $display("[TB] collision with tick");
    step(1'b0, 1'b0, 1'b1, 1'b1);
    step(1'b0, 1'b0, 1'b0, 1'b1);
    step(1'b1, 1'b0, 1'b0, 1'b0);
    step(1'b0, 1'b0, 1'b0, 1'b0);

    $display("[TB] pause hold");
    for (int i = 0; i < 10; i++) step(1'b0, 1'b1, 1'b0, 1'b1);
    step(1'b1, 1'b1, 1'b0, 1'b1);
    step(1'b0, 1'b0, 1'b0, 1'b0);
    step(1'b0, 1'b0, 1'b0, 1'b1);
    step(1'b0, 1'b1, 1'b1, 1'b1);
    step(1'b0, 1'b0, 1'b0, 1'b0);
    step(1'b1, 1'b0, 1'b0, 1'b1);
    for (int i = 0; i < 20; i++) step(1'b0, 1'b0, 1'b0, 1'b1);

    $display("[TB] asynchronous reset mid-run");
    #1 rst_n = 1'b0;
    #1 checkResetValues("async_reset");
    start      = 1'b0;
    pause      = 1'b0;
    collision  = 1'b0;
    frame_tick = 1'b0;
    modelReset();
    exp_q.delete();
    #4 rst_n = 1'b1;

    $display("[TB] long run for repeated respawns");
    step(1'b1, 1'b0, 1'b0, 1'b0);
    for (int i = 0; i < 950; i++) step(1'b0, 1'b0, 1'b0, (i % 40) != 7);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
